store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between the data cache stage and the backing data memory of the RV32I core. Stores accepted by the write-through data cache are enqueued in one cycle. They drain in FIFO order to data memory over a request/acknowledge handshake, so slow memory writes stall the pipeline only when the buffer is full. The block also flags loads that overlap pending stores and implements a fence-style full drain.

## Interface
Parameters:
- addr_width, 32, address width
- data_width, 32, store data width
- depth, 4, entries; power of two, 2..16

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- st_valid  in  1  store request from cache stage (cache write enable)
- st_funct3  in  3  store size: 000 SB, 001 SH, 010 SW
- st_addr  in  addr_width  store byte address
- st_data  in  data_width  store data, right-aligned
- st_ready  out  1  store accepted this cycle when st_valid && st_ready
- ld_valid  in  1  load in cache stage (MemRead)
- ld_addr  in  addr_width  load byte address
- ld_hazard  out  1  load overlaps a pending entry; pipeline must stall
- fence_req  in  1  request full drain
- fence_done  out  1  one-cycle pulse when drain completes
- mem_we  out  1  head entry presented to memory
- mem_funct3  out  3  head entry size
- mem_addr  out  addr_width  head entry address
- mem_wdata  out  data_width  head entry data
- mem_ack  in  1  memory has taken head entry this cycle
- count  out  $clog2(depth+1)  occupied entries
- empty  out  1  count == 0

## Operation
- Circular FIFO: wr_ptr, rd_ptr (log2(depth) bits, wrap modulo depth), count register. Each entry stores funct3, address and data.
- Enqueue on st_valid && st_ready: entry is written at wr_ptr, wr_ptr increments, count increments.
- Dequeue on mem_we && mem_ack: rd_ptr increments, count decrements. mem_ack is ignored while mem_we = 0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- mem_we = !empty. mem_funct3, mem_addr and mem_wdata are driven from the entry at rd_ptr. They must remain stable until acknowledged.
- st_ready = (count < depth) && state == IDLE. It depends only on registered state. When the buffer is full and mem_ack arrives in the same cycle, st_ready stays 0 that cycle.
- ld_hazard = ld_valid && any occupied entry has addr[addr_width-1:2] equal to ld_addr[addr_width-1:2]. The comparison is word-granular, regardless of size. It is combinational over registered entries only.
- If st_valid and ld_valid are both high, the store is enqueued. The hazard check excludes that store.
- FSM states:
  - IDLE: fence_req moves the FSM to DRAIN.
  - DRAIN: st_ready = 0. When count == 0, fence_done pulses for one cycle and the FSM returns to IDLE.
  - fence_req on an already empty buffer: DRAIN is entered, and fence_done pulses on the following cycle.
  - fence_req while in DRAIN is ignored.
- Reset: pointers = 0, count = 0, state = IDLE. Entry contents are not reset.
- Output values during and immediately after reset: st_ready 1, mem_we 0, ld_hazard 0, fence_done 0, empty 1, count 0.
- Reset mid-drain discards all pending entries. No fence_done pulse is generated.

## Timing
- An entry enqueued into an empty buffer appears on mem_* in the next cycle. Minimum store-to-memory latency is 1 cycle.
- With mem_ack held high, throughput is one entry per cycle.
- count, empty and st_ready reflect an edge in the cycle after that edge.
- fence_done is asserted in the cycle after count reaches 0 while in DRAIN.
- ld_hazard is zero-latency (combinational) relative to ld_addr and ld_valid.

## Configuration
- STORE_FWD_EN defined: the youngest matching entry is found by searching from wr_ptr-1 backward. If that entry is an SW with an exactly equal word address, ld_hazard = 0 and new outputs ld_fwd_valid = 1 and ld_fwd_data = that entry's data. Any other overlap (sub-word youngest match) raises ld_hazard.
- STORE_FWD_EN undefined: ld_fwd_valid and ld_fwd_data ports do not exist. Every overlap raises ld_hazard.

## Test plan
- Reset, then SW 0x100 = 0xDEADBEEF with mem_ack tied high:
  - mem_we = 1 with mem_addr 0x100 and mem_wdata 0xDEADBEEF the next cycle.
  - empty = 1 the cycle after that.
- mem_ack = 0, five stores (depth 4):
  - st_ready drops after the 4th; count = 4.
  - Raising mem_ack for one cycle: count = 3 and st_ready = 1 the next cycle.
  - Drain order matches enqueue order.
- Pending SB to 0x203, then load 0x200: ld_hazard = 1. Load 0x204: ld_hazard = 0.
- Fill 3 entries with mem_ack = 0, then pulse fence_req:
  - st_ready = 0 while in DRAIN.
  - Acking three entries: fence_done pulses exactly once, one cycle after count = 0.
- Wrap-around: 10 store/ack pairs with depth 4; addresses and data are delivered in order with no loss or duplication.
- STORE_FWD_EN defined, pending SW 0x300 = 0x11 then SW 0x300 = 0x22:
  - Load 0x300 gives ld_fwd_valid = 1, ld_fwd_data = 0x22, ld_hazard = 0.
  - Same test after a younger SB to 0x301: ld_hazard = 1.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: write buffer between the write-through data cache stage and data memory.
//
// Stores are enqueued in one cycle and drain in FIFO order over a mem_we/mem_ack handshake.
// Loads whose word address matches any pending entry raise ld_hazard. fence_req drains the
// buffer completely and fence_done pulses once the buffer is empty.
//
// Optional feature macro: STORE_FWD_EN. When defined, a load whose youngest matching entry
// is an SW to the identical address is forwarded (ld_fwd_valid/ld_fwd_data) instead of
// stalled. When undefined those ports do not exist.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   st_valid/st_funct3/st_addr/st_data, st_ready   store enqueue side
//   ld_valid/ld_addr, ld_hazard                    load overlap check
//   ld_fwd_valid/ld_fwd_data                       store-to-load forwarding (STORE_FWD_EN)
//   fence_req, fence_done                          full drain request / completion pulse
//   mem_we/mem_funct3/mem_addr/mem_wdata, mem_ack  head entry to data memory
//   count, empty                                   occupancy
module store_buffer #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_valid,
  input  logic [2:0]                   st_funct3,
  input  logic [addr_width-1:0]        st_addr,
  input  logic [data_width-1:0]        st_data,
  output logic                         st_ready,
  input  logic                         ld_valid,
  input  logic [addr_width-1:0]        ld_addr,
  output logic                         ld_hazard,
`ifdef STORE_FWD_EN
  output logic                         ld_fwd_valid,
  output logic [data_width-1:0]        ld_fwd_data,
`endif
  input  logic                         fence_req,
  output logic                         fence_done,
  output logic                         mem_we,
  output logic [2:0]                   mem_funct3,
  output logic [addr_width-1:0]        mem_addr,
  output logic [data_width-1:0]        mem_wdata,
  input  logic                         mem_ack,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = $clog2(depth + 1);

  typedef enum logic {StIdle, StDrain} state_e;

  state_e           state_q, state_d;
  logic [ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0] count_q, count_d;

  // Entry storage is deliberately not reset; only the pointers and count define validity.
  logic [2:0]            f3_q   [depth];
  logic [addr_width-1:0] addr_q [depth];
  logic [data_width-1:0] data_q [depth];

  logic enq, deq;

  // Ready comes purely from registered state, so a same-cycle ack on a full buffer
  // cannot open the door for a store in that cycle.
  assign st_ready = (count_q < cnt_w'(depth)) && (state_q == StIdle);
  assign enq      = st_valid && st_ready;
  assign mem_we   = (count_q != '0);
  assign deq      = mem_we && mem_ack;

  assign mem_funct3 = f3_q[rd_ptr_q];
  assign mem_addr   = addr_q[rd_ptr_q];
  assign mem_wdata  = data_q[rd_ptr_q];
  assign count      = count_q;
  assign empty      = (count_q == '0);

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fence_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fence_req) state_d = StDrain;
      end
      StDrain: begin
        if (count_q == '0) begin
          fence_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + ptr_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      f3_q[wr_ptr_q]   <= st_funct3;
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
    end
  end

  // Walk occupied entries oldest to youngest; the last hit is the youngest match, which is
  // the same entry a backward search from wr_ptr-1 would stop at first.
  logic             match_any;
  logic [ptr_w-1:0] idx;
  logic [ptr_w-1:0] young_idx;

  always_comb begin
    match_any = 1'b0;
    idx       = '0;
    young_idx = '0;
    for (int k = 0; k < int'(depth); k++) begin
      idx = rd_ptr_q + ptr_w'(k);
      if ((cnt_w'(k) < count_q) &&
          (addr_q[idx][addr_width-1:2] == ld_addr[addr_width-1:2])) begin
        match_any = 1'b1;
        young_idx = idx;
      end
    end
  end

`ifdef STORE_FWD_EN
  logic fwd_ok;
  assign fwd_ok       = match_any && (f3_q[young_idx] == 3'b010) &&
                        (addr_q[young_idx] == ld_addr);
  assign ld_fwd_valid = ld_valid && fwd_ok;
  assign ld_fwd_data  = data_q[young_idx];
  assign ld_hazard    = ld_valid && match_any && !fwd_ok;
`else
  // Byte offset of the load and the youngest index only matter for forwarding.
  logic unused_ld;
  assign unused_ld = ^{ld_addr[1:0], young_idx};
  assign ld_hazard = ld_valid && match_any;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [2:0]    st_funct3;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;
`ifdef STORE_FWD_EN
  logic          ld_fwd_valid;
  logic [DW-1:0] ld_fwd_data;
`endif
  logic          fence_req;
  logic          fence_done;
  logic          mem_we;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [2:0]    count;
  logic          empty;

  store_buffer #(.addr_width(AW), .data_width(DW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
`ifdef STORE_FWD_EN
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
`endif
    .fence_req(fence_req), .fence_done(fence_done),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t q[$];
  bit     drain;
  bit     model_ok;
  int     n_chk;
  int     n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit     any;
    int     yi;
    bit     fwd;
    any = 0;
    yi  = -1;
    foreach (q[i]) if (q[i].addr[AW-1:2] == ld_addr[AW-1:2]) begin any = 1; yi = i; end
    fwd = 0;
`ifdef STORE_FWD_EN
    fwd = any && (q[yi].f3 == 3'b010) && (q[yi].addr == ld_addr);
    chk("m_fwd_valid", ld_fwd_valid, ld_valid && fwd);
    if (ld_valid && fwd) chk("m_fwd_data", ld_fwd_data, q[yi].data);
`endif
    chk("m_st_ready", st_ready, (q.size() < DEPTH) && !drain);
    chk("m_mem_we", mem_we, q.size() > 0);
    chk("m_count", count, q.size());
    chk("m_empty", empty, q.size() == 0);
    chk("m_ld_hazard", ld_hazard, ld_valid && any && !fwd);
    chk("m_fence_done", fence_done, drain && q.size() == 0);
    if (q.size() > 0) begin
      chk("m_mem_funct3", mem_funct3, q[0].f3);
      chk("m_mem_addr", mem_addr, q[0].addr);
      chk("m_mem_wdata", mem_wdata, q[0].data);
    end
  endtask

  task automatic update_model();
    bit en, de;
    if (rst) begin
      q.delete();
      drain    = 0;
      model_ok = 1;
    end else begin
      en = st_valid && (q.size() < DEPTH) && !drain;
      de = (q.size() > 0) && mem_ack;
      if (drain && q.size() == 0) drain = 0;
      else if (!drain && fence_req) drain = 1;
      if (de) void'(q.pop_front());
      if (en) q.push_back('{f3: st_funct3, addr: st_addr, data: st_data});
    end
  endtask

  task automatic tick();
    #1;
    if (model_ok) check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    st_valid = 0; ld_valid = 0; fence_req = 0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid = 1; st_funct3 = f3; st_addr = a; st_data = d;
    tick();
    st_valid = 0;
  endtask

  task automatic drain_all();
    idle();
    mem_ack = 1;
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; model_ok = 0; drain = 0;
    rst = 1; idle(); mem_ack = 0;
    st_funct3 = 0; st_addr = 0; st_data = 0; ld_addr = 0;
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_fence_done", fence_done, 0);
    chk("rst_ld_hazard", ld_hazard, 0);

    // Single SW with ack tied high.
    mem_ack = 1;
    store(3'b010, 32'h100, 32'hDEADBEEF);
    #1;
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_addr", mem_addr, 32'h100);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("sw_empty_after", empty, 1);

    // Fill with ack low; fifth store is refused.
    mem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      store(3'b010, 32'h400 + 4 * i, 32'h10 + i);
      if (i == 3) begin
        chk("full_count", count, 4);
        chk("full_st_ready", st_ready, 0);
      end
    end
    #1 chk("full_head", mem_addr, 32'h400);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("ack1_count", count, 3);
    chk("ack1_st_ready", st_ready, 1);
    mem_ack = 1;
    for (int i = 1; i < 4; i++) begin
      #1 chk("order_addr", mem_addr, 32'h400 + 4 * i);
      chk("order_data", mem_wdata, 32'h10 + i);
      tick();
    end
    chk("order_empty", empty, 1);

    // Word-granular load hazard against a pending SB.
    mem_ack = 0;
    store(3'b000, 32'h203, 32'hAB);
    ld_valid = 1; ld_addr = 32'h200;
    #1 chk("haz_same_word", ld_hazard, 1);
    ld_addr = 32'h204;
    #1 chk("haz_next_word", ld_hazard, 0);
    tick();
    drain_all();

    // Fence drain with three pending entries.
    mem_ack = 0;
    for (int i = 0; i < 3; i++) store(3'b010, 32'h700 + 4 * i, i);
    fence_req = 1;
    tick();
    fence_req = 0;
    #1 chk("fence_st_ready", st_ready, 0);
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fence_done_early", fence_done, 0);
      tick();
    end
    chk("fence_done_pulse", fence_done, 1);
    chk("fence_count0", count, 0);
    tick();
    chk("fence_done_once", fence_done, 0);
    chk("fence_ready_back", st_ready, 1);

    // Fence on an empty buffer.
    fence_req = 1;
    tick();
    fence_req = 0;
    chk("fence_empty_pulse", fence_done, 1);
    tick();

    // Wrap-around: ten store/ack pairs.
    mem_ack = 1;
    for (int i = 0; i < 10; i++) begin
      store(3'b010, 32'h500 + 4 * i, 32'hC0DE0000 + i);
      #1 chk("wrap_addr", mem_addr, 32'h500 + 4 * i);
      chk("wrap_data", mem_wdata, 32'hC0DE0000 + i);
      tick();
      chk("wrap_empty", empty, 1);
    end

    // Reset in the middle of a drain discards entries, no pulse.
    mem_ack = 0;
    store(3'b010, 32'h800, 1);
    store(3'b010, 32'h804, 2);
    fence_req = 1;
    tick();
    fence_req = 0;
    rst = 1;
    tick();
    rst = 0;
    #1 chk("rstmid_count", count, 0);
    chk("rstmid_fence_done", fence_done, 0);
    chk("rstmid_st_ready", st_ready, 1);
    chk("rstmid_mem_we", mem_we, 0);

`ifdef STORE_FWD_EN
    store(3'b010, 32'h300, 32'h11);
    store(3'b010, 32'h300, 32'h22);
    ld_valid = 1; ld_addr = 32'h300;
    #1 chk("fwd_valid", ld_fwd_valid, 1);
    chk("fwd_data", ld_fwd_data, 32'h22);
    chk("fwd_no_hazard", ld_hazard, 0);
    tick();
    ld_valid = 0;
    store(3'b000, 32'h301, 32'h5);
    ld_valid = 1; ld_addr = 32'h300;
    #1 chk("fwd_sb_hazard", ld_hazard, 1);
    chk("fwd_sb_novalid", ld_fwd_valid, 0);
    tick();
    drain_all();
`endif

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 499) == 0);
      st_valid  = $urandom_range(0, 1) == 1;
      st_funct3 = 3'($urandom_range(0, 2));
      st_addr   = 32'h600 + $urandom_range(0, 15);
      st_data   = $urandom;
      ld_valid  = $urandom_range(0, 1) == 1;
      ld_addr   = 32'h600 + $urandom_range(0, 19);
      fence_req = ($urandom_range(0, 19) == 0);
      mem_ack   = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 0;
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
